// File: rtl/d5m_pix_pkg.sv
// Shared types and helpers for the D5M Bayer-to-RGB565 binning path.
package d5m_pix_pkg;

  localparam int unsigned BAYER_W  = 12;
  localparam int unsigned RGB565_W = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [BAYER_W-1:0] g1;
    logic [BAYER_W-1:0] r;
  } bayer_pair_t;

  typedef struct packed {
    logic    sof;
    logic    eol;
    rgb565_t pix;
  } fifo_entry_t;

  // Both greens are summed at full precision so the 6-bit green keeps the extra bit.
  function automatic rgb565_t pack_rgb565(input logic [BAYER_W-1:0] r,
                                          input logic [BAYER_W-1:0] g1,
                                          input logic [BAYER_W-1:0] g2,
                                          input logic [BAYER_W-1:0] b);
    logic [BAYER_W:0] g_sum;
    rgb565_t          px;
    g_sum = {1'b0, g1} + {1'b0, g2};
    px.r  = r[BAYER_W-1 -: 5];
    px.g  = g_sum[BAYER_W -: 6];
    px.b  = b[BAYER_W-1 -: 5];
    return px;
  endfunction

endpackage

// File: rtl/d5m_pix_fifo.sv
// Synchronous output FIFO for binned pixels; a push while full succeeds only if a pop frees a slot.
module d5m_pix_fifo
  import d5m_pix_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t wdata,
  input  logic        pop,
  output fifo_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == FullCnt);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/d5m_bayer_bin_rgb565.sv
// GRBG Bayer 2x2 binning to RGB565 with output FIFO, overflow and width-error flags.
// Optional D5M_BAYER_OVF_CNT_EN adds a saturating dropped-pixel counter port ovf_count.
module d5m_bayer_bin_rgb565
  import d5m_pix_pkg::*;
#(
  parameter int unsigned MAX_WIDTH  = 1280,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  input  logic        in_sof,
  input  logic        in_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sof,
  output logic        out_eol,
  output logic        overflow,
  output logic        width_err
`ifdef D5M_BAYER_OVF_CNT_EN
  ,
  output logic [15:0] ovf_count
`endif
);

  localparam int unsigned LbDepth = MAX_WIDTH / 2;
  localparam int unsigned LbAw    = $clog2(LbDepth);
  localparam int unsigned Cw      = $clog2(MAX_WIDTH + 1);

  logic [Cw-1:0]      col_q, col_d, cur_col;
  logic               row_odd_q, row_odd_d, cur_odd;
  logic [BAYER_W-1:0] g1_q, b_q;
  logic               sof_pend_q, sof_pend_d;
  logic               st_valid_q;
  fifo_entry_t        st_entry_q, st_entry_d;
  logic               overflow_q, width_err_q;
  bayer_pair_t        lb_mem [LbDepth];
  bayer_pair_t        lb_rd_q;

  logic               in_range, pix_ok, even_col;
  logic               lb_we, lb_re, g1_we, g2_hit, lone_eol, drop;
  logic [LbAw-1:0]    lb_addr;
  fifo_entry_t        fifo_wdata, fifo_rdata;
  logic               fifo_full, fifo_empty;

  // in_sof restarts the geometry on the very pixel that carries it.
  always_comb begin
    cur_col    = in_sof ? '0 : col_q;
    cur_odd    = in_sof ? 1'b0 : row_odd_q;
    in_range   = cur_col < Cw'(MAX_WIDTH);
    pix_ok     = in_valid && in_range;
    even_col   = ~cur_col[0];
    lb_addr    = LbAw'(cur_col >> 1);
    g1_we      = pix_ok && !cur_odd && even_col;
    lb_we      = pix_ok && !cur_odd && !even_col;
    lb_re      = pix_ok && cur_odd && even_col;
    g2_hit     = pix_ok && cur_odd && !even_col;
    lone_eol   = lb_re && in_eol;

    col_d      = col_q;
    row_odd_d  = row_odd_q;
    if (in_valid) begin
      if (in_eol)        col_d = '0;
      else if (in_range) col_d = cur_col + 1'b1;
      else               col_d = cur_col;
      row_odd_d = cur_odd ^ in_eol;
    end

    sof_pend_d = sof_pend_q;
    if (in_valid && in_sof) sof_pend_d = 1'b1;
    else if (g2_hit)        sof_pend_d = 1'b0;

    st_entry_d     = st_entry_q;
    st_entry_d.sof = sof_pend_q;
    st_entry_d.eol = in_eol;
    st_entry_d.pix = pack_rgb565(lb_rd_q.r, lb_rd_q.g1, in_data, b_q);
  end

  // An odd-width line's trailing lone pixel hands its eol to the output still awaiting its write.
  always_comb begin
    fifo_wdata     = st_entry_q;
    fifo_wdata.eol = st_entry_q.eol | lone_eol;
  end

  assign drop = st_valid_q && fifo_full && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_odd_q   <= 1'b0;
      g1_q        <= '0;
      b_q         <= '0;
      sof_pend_q  <= 1'b0;
      st_valid_q  <= 1'b0;
      st_entry_q  <= '0;
      overflow_q  <= 1'b0;
      width_err_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_odd_q  <= row_odd_d;
      sof_pend_q <= sof_pend_d;
      st_valid_q <= g2_hit;
      if (g1_we)  g1_q       <= in_data;
      if (lb_re)  b_q        <= in_data;
      if (g2_hit) st_entry_q <= st_entry_d;
      if (drop)                    overflow_q <= 1'b1;
      else if (in_valid && in_sof) overflow_q <= 1'b0;
      if (in_valid && !in_range)   width_err_q <= 1'b1;
      else if (in_valid && in_sof) width_err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) lb_mem[lb_addr] <= '{g1: g1_q, r: in_data};
    if (lb_re) lb_rd_q <= lb_mem[lb_addr];
  end

  d5m_pix_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (st_valid_q),
    .wdata(fifo_wdata),
    .pop  (out_ready),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_rdata.pix;
  assign out_sof   = !fifo_empty && fifo_rdata.sof;
  assign out_eol   = !fifo_empty && fifo_rdata.eol;
  assign overflow  = overflow_q;
  assign width_err = width_err_q;

`ifdef D5M_BAYER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;
  always_ff @(posedge clk) begin
    if (reset)                              ovf_cnt_q <= '0;
    else if (drop && (ovf_cnt_q != '1))     ovf_cnt_q <= ovf_cnt_q + 1'b1;
  end
  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_d5m_bayer_bin_rgb565.sv
// Scoreboard bench for d5m_bayer_bin_rgb565: directed frames, monitor pops expected outputs.
module tb_d5m_bayer_bin_rgb565;

  localparam int unsigned MaxW = 1280;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_sof, in_eol, out_ready;
  logic [11:0] in_data;
  logic        out_valid, out_sof, out_eol, overflow, width_err;
  logic [15:0] out_data;
`ifdef D5M_BAYER_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  d5m_bayer_bin_rgb565 #(
    .MAX_WIDTH (MaxW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .in_eol   (in_eol),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .overflow (overflow),
`ifdef D5M_BAYER_OVF_CNT_EN
    .ovf_count(ovf_count),
`endif
    .width_err(width_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic pix(input logic [11:0] d, input logic s, input logic e);
    in_valid = 1'b1; in_data = d; in_sof = s; in_eol = e;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_row(input int w, input logic [11:0] a, input logic [11:0] b,
                          input logic first_sof);
    for (int i = 0; i < w; i++) pix((i % 2 == 0) ? a : b, first_sof && (i == 0), i == w - 1);
  endtask

  task automatic send_frame(input int w, input int rows, input logic [11:0] g1,
                            input logic [11:0] r, input logic [11:0] b, input logic [11:0] g2);
    for (int row = 0; row < rows; row++) begin
      if (row % 2 == 0) send_row(w, g1, r, row == 0);
      else              send_row(w, b, g2, 1'b0);
    end
  endtask

  task automatic expect_frame(input int pairs, input int out_rows, input logic [15:0] val,
                              input logic last_eol);
    for (int row = 0; row < out_rows; row++)
      for (int p = 0; p < pairs; p++)
        exp_q.push_back({(row == 0) && (p == 0), last_eol && (p == pairs - 1), val});
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  initial begin
    logic [17:0] exp_e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got %h required none", {out_sof, out_eol, out_data});
        end else begin
          exp_e = exp_q.pop_front();
          if ({out_sof, out_eol, out_data} !== exp_e) begin
            n_fail++;
            $display("FAIL out_pixel: got %h required %h", {out_sof, out_eol, out_data}, exp_e);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_data = '0;
    out_ready = 1'b1;
    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sof_eol", {out_sof, out_eol}, 0);
    check("rst_overflow", overflow, 0);
    check("rst_width_err", width_err, 0);
    reset = 1'b0;
    idle(2);

    // 1: basic 4x2 frame
    expect_frame(2, 1, 16'hFC00, 1'b1);
    send_frame(4, 2, 12'h800, 12'hFFF, 12'h000, 12'h800);
    wait_drain("t1_drain");

    // 2: stalled sink, FIFO fills then drops
    out_ready = 1'b0;
    expect_frame(4, 1, 16'hFC00, 1'b1);
    send_frame(8, 6, 12'h800, 12'hFFF, 12'h000, 12'h800);
    idle(52);
    check("t2_out_valid_held", out_valid, 1);
    check("t2_head_data", out_data, 16'hFC00);
    check("t2_overflow", overflow, 1);
`ifdef D5M_BAYER_OVF_CNT_EN
    check("t2_ovf_count", ovf_count, 8);
`endif
    out_ready = 1'b1;
    wait_drain("t2_drain");
    check("t2_overflow_sticky", overflow, 1);

    // 3: sof mid odd row; pair completed before the restart is already committed
    exp_q.push_back({1'b1, 1'b0, 16'h089F});
    expect_frame(2, 1, 16'h089F, 1'b1);
    send_row(4, 12'h100, 12'h080, 1'b1);
    check("t3_overflow_cleared", overflow, 0);
    pix(12'hF80, 1'b0, 1'b0);
    pix(12'h100, 1'b0, 1'b0);
    pix(12'hF80, 1'b0, 1'b0);
    send_frame(4, 2, 12'h100, 12'h080, 12'hF80, 12'h100);
    wait_drain("t3_drain");

    // 4: over-wide line
    expect_frame(MaxW / 2, 1, 16'hFC00, 1'b0);
    send_frame(MaxW + 4, 2, 12'h800, 12'hFFF, 12'h000, 12'h800);
    wait_drain("t4_drain");
    check("t4_width_err", width_err, 1);

    // 5: odd width 5 with distinct pairs
    exp_q.push_back({1'b1, 1'b0, 16'h3A05});
    exp_q.push_back({1'b0, 1'b1, 16'hA07F});
    pix(12'h400, 1'b1, 1'b0); pix(12'h380, 1'b0, 1'b0);
    pix(12'h0C0, 1'b0, 1'b0); pix(12'hA00, 1'b0, 1'b0); pix(12'h123, 1'b0, 1'b1);
    check("t5_width_err_cleared", width_err, 0);
    pix(12'h280, 1'b0, 1'b0); pix(12'h400, 1'b0, 1'b0);
    pix(12'hFFF, 1'b0, 1'b0); pix(12'h0C0, 1'b0, 1'b0); pix(12'h456, 1'b0, 1'b1);
    wait_drain("t5_drain");

    // 6: reset during odd row with a full FIFO
    out_ready = 1'b0;
    send_frame(8, 6, 12'h800, 12'hFFF, 12'h000, 12'h800);
    pix(12'h000, 1'b1, 1'b0);
    send_row(8, 12'h800, 12'hFFF, 1'b0);
    pix(12'h000, 1'b0, 1'b0);
    pix(12'h800, 1'b0, 1'b0);
    check("t6_pre_out_valid", out_valid, 1);
    reset = 1'b1;
    idle(1);
    check("t6_out_valid", out_valid, 0);
    check("t6_flags", {out_sof, out_eol, overflow, width_err}, 0);
    check("t6_out_data", out_data, 0);
`ifdef D5M_BAYER_OVF_CNT_EN
    check("t6_ovf_count", ovf_count, 0);
`endif
    exp_q.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Recovery after reset, starting on an even row
    expect_frame(2, 1, 16'hFC00, 1'b1);
    send_frame(4, 2, 12'h800, 12'hFFF, 12'h000, 12'h800);
    wait_drain("t6_recover_drain");
    idle(5);
    check("final_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
